writeback_stage_param: RTL
==========================

// Module: writeback_stage_param
// PURPOSE
//  Parametrised MIPS write-back stage. Owns the MEM/WB pipeline latch and selects the result
//  from ALU, memory (with byte/half extraction and sign/zero extend) or link address.
//  Owns the register file; writes the selected result and serves two bypassed read ports.
//  Sits after the memory stage; ID reads operands from it, forwarding unit watches wb_* outputs.
// PARAMETERS
//  DATA_W    32  datapath width; multiple of 16, >=32
//  NUM_REGS  32  register count; power of 2; reg 0 hard-wired to zero
//  ADDR_W    $clog2(NUM_REGS)  register index width (derived localparam)
//  OFF_W     $clog2(DATA_W/8)  byte-offset width (derived localparam)
// PORTS
//  Clock            in   1       rising-edge clock
//  Reset            in   1       asynchronous, active-high
//  Hold             in   1       1 = freeze MEM/WB latch (pipeline stall)
//  InValid          in   1       MEM stage presents a live instruction
//  InRegWrite       in   1       instruction writes a register
//  InWbSel          in   2       00 ALU, 01 MEM, 10 LINK, 11 reserved (treated as ALU)
//  InLoadSize       in   2       00 word, 01 half, 10 byte, 11 reserved (treated as word)
//  InLoadUnsigned   in   1       1 = zero-extend, 0 = sign-extend sub-word loads
//  InByteOff        in   OFF_W   byte address of load within the word
//  InALUResult      in   DATA_W  ALU result
//  InMemData        in   DATA_W  raw memory read word
//  InLinkAddr       in   DATA_W  return address for jal/jalr
//  InRd             in   ADDR_W  destination register
//  RsAddr, RtAddr   in   ADDR_W  read-port addresses
//  RsData, RtData   out  DATA_W  read-port data (combinational)
//  WbValid          out  1       latched instruction live
//  WbRegWrite       out  1       latched write enable, gated by WbValid and WbRd != 0
//  WbRd             out  ADDR_W  latched destination
//  WbData           out  DATA_W  selected, extended result (combinational from latch)
// BEHAVIOUR
//  - Reset (async): latch cleared (WbValid=0, WbRegWrite=0, WbRd=0, all fields 0);
//    all registers = 0; WbData = 0.
//  - Latch: on posedge with Hold=0, capture all In* fields; Hold=1 keeps contents.
//  - Write condition: WbValid & latched RegWrite & WbRd != 0. Write commits at the posedge
//    ending the cycle in which the instruction sits in the latch. During Hold the same value
//    is re-written each cycle (idempotent).
//  - Latency: inputs to register-file update = 2 edges; inputs to WbData = 1 edge.
//  - Load extract (little-endian): byte = bits[8*off +: 8]; half = bits[16*off[OFF_W-1:1] +: 16];
//    word ignores off. off[0] on half is ignored (no alignment trap here).
//  - Extension: sign bit of the extracted field copied to DATA_W unless InLoadUnsigned.
//  - WbSel 00/11 -> ALU; 01 -> extended mem; 10 -> link. LoadSize applies to MEM only.
//  - Read ports: addr 0 -> 0. If addr == WbRd and the write condition holds this cycle,
//    return WbData (write-through bypass); else the array value.
//  - Rs and Rt may both equal WbRd; both bypass.
//  - Reset mid-instruction: latched write is discarded; no register update.
// STRUCTURE
//  - Shared include wb_defs.vh: WB_SEL_ALU/MEM/LINK, LOAD_WORD/HALF/BYTE encodings.
//  - One sub-module wb_regfile (NUM_REGS x DATA_W, 1 write / 2 async read, zero reg, bypass).
//  - Latch, extract/extend and result mux stay in this module.
// TESTING
//  1. Reset mid-run: pulse Reset between edges -> WbValid=0 immediately; all reads return 0.
//  2. ALU write: InRd=5, ALU=0x12345678, RegWrite=1 -> after 2 edges RsAddr=5 reads 0x12345678.
//  3. lb, off=3, mem=0x80FF7F01, signed -> 0xFFFFFF80; lbu -> 0x00000080;
//     lh off=2 signed -> 0xFFFF80FF.
//  4. Bypass: RtAddr=9 while latch writes r9=0xCAFEF00D -> RtData=0xCAFEF00D same cycle.
//  5. r0 guard: InRd=0, ALU=0xFFFFFFFF, RegWrite=1 -> WbRegWrite=0; r0 reads 0.
//  6. Hold: Hold=1 for 3 cycles, inputs changing -> WbRd/WbData stable; only latched value written.

Source files
------------

// File: rtl/writeback_stage_param_pkg.sv
// Shared encodings for the MIPS write-back stage: result-select and load-size codes.
package writeback_stage_param_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_MEM  = 2'b01;
  localparam logic [1:0] WB_SEL_LINK = 2'b10;

  localparam logic [1:0] LOAD_WORD = 2'b00;
  localparam logic [1:0] LOAD_HALF = 2'b01;
  localparam logic [1:0] LOAD_BYTE = 2'b10;

endpackage

// File: rtl/writeback_stage_param_if.sv
// MEM->WB bundle: incoming instruction fields, register read ports and write-back outputs.
interface writeback_stage_param_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32
);
  localparam int unsigned ADDR_W = $clog2(NUM_REGS);
  localparam int unsigned OFF_W  = $clog2(DATA_W / 8);

  logic              hold;
  logic              inValid;
  logic              inRegWrite;
  logic [1:0]        inWbSel;
  logic [1:0]        inLoadSize;
  logic              inLoadUnsigned;
  logic [OFF_W-1:0]  inByteOff;
  logic [DATA_W-1:0] inAluResult;
  logic [DATA_W-1:0] inMemData;
  logic [DATA_W-1:0] inLinkAddr;
  logic [ADDR_W-1:0] inRd;
  logic [ADDR_W-1:0] rsAddr;
  logic [ADDR_W-1:0] rtAddr;
  logic [DATA_W-1:0] rsData;
  logic [DATA_W-1:0] rtData;
  logic              wbValid;
  logic              wbRegWrite;
  logic [ADDR_W-1:0] wbRd;
  logic [DATA_W-1:0] wbData;

  modport master (
    output hold, inValid, inRegWrite, inWbSel, inLoadSize, inLoadUnsigned, inByteOff,
           inAluResult, inMemData, inLinkAddr, inRd, rsAddr, rtAddr,
    input  rsData, rtData, wbValid, wbRegWrite, wbRd, wbData
  );

  modport slave (
    input  hold, inValid, inRegWrite, inWbSel, inLoadSize, inLoadUnsigned, inByteOff,
           inAluResult, inMemData, inLinkAddr, inRd, rsAddr, rtAddr,
    output rsData, rtData, wbValid, wbRegWrite, wbRd, wbData
  );
endinterface

// File: rtl/writeback_stage_param_regfile.sv
// Register file: one write port, two async read ports, r0 reads zero, write-through bypass.
module writeback_stage_param_regfile #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wAddr,
  input  logic [DATA_W-1:0] wData,
  input  logic [ADDR_W-1:0] rsAddr,
  input  logic [ADDR_W-1:0] rtAddr,
  output logic [DATA_W-1:0] rsData,
  output logic [DATA_W-1:0] rtData
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else if (we && (wAddr != '0)) begin
      regs[wAddr] <= wData;
    end
  end

  // Same-cycle write is forwarded so ID sees the value being committed this edge.
  always_comb begin
    rsData = regs[rsAddr];
    rtData = regs[rtAddr];
    if (we && (rsAddr == wAddr)) rsData = wData;
    if (we && (rtAddr == wAddr)) rtData = wData;
    if (rsAddr == '0) rsData = '0;
    if (rtAddr == '0) rtData = '0;
  end

endmodule

// File: rtl/writeback_stage_param.sv
// MIPS write-back stage: MEM/WB latch, load extract/extend, result select and register file.
module writeback_stage_param
  import writeback_stage_param_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32
) (
  input logic                   clk,
  input logic                   rst,
  writeback_stage_param_if.slave bus
);

  localparam int unsigned ADDR_W = $clog2(NUM_REGS);
  localparam int unsigned OFF_W  = $clog2(DATA_W / 8);

  logic              valid;
  logic              regWrite;
  logic [1:0]        wbSel;
  logic [1:0]        loadSize;
  logic              loadUnsigned;
  logic [OFF_W-1:0]  byteOff;
  logic [DATA_W-1:0] aluResult;
  logic [DATA_W-1:0] memData;
  logic [DATA_W-1:0] linkAddr;
  logic [ADDR_W-1:0] rd;

  logic [OFF_W-2:0]  halfIdx;
  logic [7:0]        byteField;
  logic [15:0]       halfField;
  logic [DATA_W-1:0] memExt;
  logic [DATA_W-1:0] result;
  logic              writeEn;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid        <= 1'b0;
      regWrite     <= 1'b0;
      wbSel        <= '0;
      loadSize     <= '0;
      loadUnsigned <= 1'b0;
      byteOff      <= '0;
      aluResult    <= '0;
      memData      <= '0;
      linkAddr     <= '0;
      rd           <= '0;
    end else if (!bus.hold) begin
      valid        <= bus.inValid;
      regWrite     <= bus.inRegWrite;
      wbSel        <= bus.inWbSel;
      loadSize     <= bus.inLoadSize;
      loadUnsigned <= bus.inLoadUnsigned;
      byteOff      <= bus.inByteOff;
      aluResult    <= bus.inAluResult;
      memData      <= bus.inMemData;
      linkAddr     <= bus.inLinkAddr;
      rd           <= bus.inRd;
    end
  end

  // Little-endian lane extract; the low offset bit is ignored for halfwords.
  always_comb begin
    halfIdx   = byteOff[OFF_W-1:1];
    byteField = memData[8*byteOff +: 8];
    halfField = memData[16*halfIdx +: 16];
    case (loadSize)
      LOAD_BYTE: memExt = {{(DATA_W-8){byteField[7] & ~loadUnsigned}}, byteField};
      LOAD_HALF: memExt = {{(DATA_W-16){halfField[15] & ~loadUnsigned}}, halfField};
      LOAD_WORD: memExt = memData;
      default:   memExt = memData;
    endcase
    case (wbSel)
      WB_SEL_MEM:  result = memExt;
      WB_SEL_LINK: result = linkAddr;
      WB_SEL_ALU:  result = aluResult;
      default:     result = aluResult;
    endcase
  end

  assign writeEn        = valid & regWrite & (rd != '0);
  assign bus.wbValid    = valid;
  assign bus.wbRegWrite = writeEn;
  assign bus.wbRd       = rd;
  assign bus.wbData     = result;

  writeback_stage_param_regfile #(
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS),
    .ADDR_W  (ADDR_W)
  ) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (writeEn),
    .wAddr (rd),
    .wData (result),
    .rsAddr(bus.rsAddr),
    .rtAddr(bus.rtAddr),
    .rsData(bus.rsData),
    .rtData(bus.rtData)
  );

endmodule
